// File: rtl/axi_arbiter_s2m_s3_pkg.sv
// Shared encodings for the s2m response arbiter: FSM states and arbitration modes.
package axi_arbiter_s2m_s3_pkg;

  localparam int unsigned NumSlv = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StLock = 1'b1
  } arb_state_e;

  typedef enum logic {
    ArbFixed = 1'b0,
    ArbRr    = 1'b1
  } arb_type_e;

endpackage

// File: rtl/axi_arbiter_s2m_s3_if.sv
// Per-master R/B response request and grant bundle between the slave response sources and
// the arbiter.
interface axi_arbiter_s2m_s3_if #(
  parameter int unsigned NUM = 3
);
  logic [NUM-1:0] RSELECT;
  logic [NUM-1:0] RVALID;
  logic [NUM-1:0] RREADY;
  logic [NUM-1:0] RLAST;
  logic [NUM-1:0] RGRANT;
  logic [NUM-1:0] BSELECT;
  logic [NUM-1:0] BVALID;
  logic [NUM-1:0] BREADY;
  logic [NUM-1:0] BGRANT;

  modport mst (
    output RSELECT, RVALID, RREADY, RLAST, BSELECT, BVALID, BREADY,
    input  RGRANT, BGRANT
  );

  modport slv (
    input  RSELECT, RVALID, RREADY, RLAST, BSELECT, BVALID, BREADY,
    output RGRANT, BGRANT
  );
endinterface

// File: rtl/axi_resp_lock_arb.sv
// Lock-until-last arbiter for one response channel: zero-latency selection in idle, grant held
// until the completing handshake, pointer advanced only on completion.
module axi_resp_lock_arb
  import axi_arbiter_s2m_s3_pkg::*;
#(
  parameter int unsigned Num = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           arbiter_type_i,
  input  logic [Num-1:0] req_i,
  input  logic [Num-1:0] valid_i,
  input  logic [Num-1:0] ready_i,
  input  logic [Num-1:0] last_i,
  output logic [Num-1:0] grant_o
);

  localparam int unsigned IdxW = (Num > 1) ? $clog2(Num) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Num - 1);

  arb_state_e state_q, state_d;
  logic [Num-1:0]  hold_q, hold_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx;
  logic [Num-1:0]  sel, grant;
  logic            found, done;

  function automatic logic [IdxW-1:0] oh2idx(logic [Num-1:0] oh);
    oh2idx = '0;
    for (int unsigned i = 0; i < Num; i++) begin
      if (oh[i]) oh2idx = IdxW'(i);
    end
  endfunction

  // Fixed mode scans 0..Num-1; round robin scans ptr+1 upward with wrap.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = ptr_q;
    for (int unsigned k = 0; k < Num; k++) begin
      if (arbiter_type_i == ArbRr) idx = (idx == LastIdx) ? '0 : idx + 1'b1;
      else                         idx = IdxW'(k);
      if (!found && req_i[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle:  grant = sel;
      StLock:  grant = hold_q;
      default: grant = '0;
    endcase
    done = |(grant & valid_i & ready_i & last_i);
    if (|grant) begin
      if (done) begin
        state_d = StIdle;
        hold_d  = '0;
        ptr_d   = oh2idx(grant);
      end else if (state_q == StIdle) begin
        state_d = StLock;
        hold_d  = grant;
      end
    end
  end

  // Idle selection is combinational, so gate it to keep grants low throughout reset.
  assign grant_o = rst_ni ? grant : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      hold_q  <= '0;
      ptr_q   <= LastIdx;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_arbiter_s2m_s3.sv
// Per-master-port s2m response arbiter: independent R and B lock arbiters driving one-hot
// grants for the response muxes.
module axi_arbiter_s2m_s3
  import axi_arbiter_s2m_s3_pkg::*;
#(
  parameter int unsigned NUM = NumSlv
) (
  input logic                  AXI_CLK,
  input logic                  AXI_RSTn,
  input logic                  arbiter_type,
  axi_arbiter_s2m_s3_if.slv    bus
);

  axi_resp_lock_arb #(
    .Num (NUM)
  ) u_r_arb (
    .clk_i          (AXI_CLK),
    .rst_ni         (AXI_RSTn),
    .arbiter_type_i (arbiter_type),
    .req_i          (bus.RSELECT & bus.RVALID),
    .valid_i        (bus.RVALID),
    .ready_i        (bus.RREADY),
    .last_i         (bus.RLAST),
    .grant_o        (bus.RGRANT)
  );

  // B responses are single-beat, so every accepted handshake completes.
  axi_resp_lock_arb #(
    .Num (NUM)
  ) u_b_arb (
    .clk_i          (AXI_CLK),
    .rst_ni         (AXI_RSTn),
    .arbiter_type_i (arbiter_type),
    .req_i          (bus.BSELECT & bus.BVALID),
    .valid_i        (bus.BVALID),
    .ready_i        (bus.BREADY),
    .last_i         ({NUM{1'b1}}),
    .grant_o        (bus.BGRANT)
  );

endmodule

// File: tb/tb_axi_arbiter_s2m_s3.sv
// Directed scoreboard bench for axi_arbiter_s2m_s3: each vector pushes its expected grants, a
// negedge monitor pops and compares.
module tb_axi_arbiter_s2m_s3;

  typedef struct {
    logic [2:0] r;
    logic [2:0] b;
    string      nm;
  } exp_t;

  logic clk;
  logic rst_n;
  logic arb;
  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;

  axi_arbiter_s2m_s3_if #(.NUM(3)) bus ();

  axi_arbiter_s2m_s3 #(
    .NUM (3)
  ) dut (
    .AXI_CLK      (clk),
    .AXI_RSTn     (rst_n),
    .arbiter_type (arb),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (bus.RGRANT !== e.r || bus.BGRANT !== e.b) begin
        n_miss++;
        $display("FAIL %s: RGRANT=%b BGRANT=%b, required RGRANT=%b BGRANT=%b",
                 e.nm, bus.RGRANT, bus.BGRANT, e.r, e.b);
      end
    end
  end

  // Drive one cycle of inputs just after the edge; the monitor checks at the following negedge.
  task automatic vec(input string nm, input logic rstn, input logic at,
                     input logic [2:0] rs, input logic [2:0] rv, input logic [2:0] rr,
                     input logic [2:0] rl, input logic [2:0] bs, input logic [2:0] bv,
                     input logic [2:0] br, input logic [2:0] er, input logic [2:0] eb);
    exp_t e;
    rst_n       = rstn;
    arb         = at;
    bus.RSELECT = rs;
    bus.RVALID  = rv;
    bus.RREADY  = rr;
    bus.RLAST   = rl;
    bus.BSELECT = bs;
    bus.BVALID  = bv;
    bus.BREADY  = br;
    e.r  = er;
    e.b  = eb;
    e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    arb    = 1'b0;
    bus.RSELECT = '0; bus.RVALID = '0; bus.RREADY = '0; bus.RLAST = '0;
    bus.BSELECT = '0; bus.BVALID = '0; bus.BREADY = '0;
    @(posedge clk);
    #1;

    //   name          rstn arb  rsel    rvld    rrdy    rlast   bsel    bvld    brdy    expR    expB
    vec("reset_req",   0, 0, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000);
    vec("fix_r0",      1, 0, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("fix_r1",      1, 0, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("fix_r2",      1, 0, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    // Round robin from ptr=0 after the fixed-mode completions.
    vec("rr_0",        1, 1, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("rr_1",        1, 1, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000);
    vec("rr_2",        1, 1, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("rr_3",        1, 1, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("idle_0",      1, 1, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    // Slave1 4-beat burst, fixed mode, slave0 joins mid-burst and must wait.
    vec("burst_b1",    1, 0, 3'b010, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("burst_stall", 1, 0, 3'b011, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("burst_b2",    1, 0, 3'b011, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("burst_b3",    1, 0, 3'b011, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("burst_last",  1, 0, 3'b011, 3'b011, 3'b111, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("after_burst", 1, 0, 3'b001, 3'b001, 3'b111, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("idle_1",      1, 0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    // B channel held while BREADY low, concurrent single-beat R traffic from slave0.
    vec("b_hold0",     1, 0, 3'b001, 3'b001, 3'b111, 3'b001, 3'b110, 3'b110, 3'b000, 3'b001, 3'b010);
    vec("b_hold1",     1, 0, 3'b001, 3'b001, 3'b111, 3'b001, 3'b110, 3'b110, 3'b000, 3'b001, 3'b010);
    vec("b_hold2",     1, 0, 3'b001, 3'b001, 3'b111, 3'b001, 3'b110, 3'b110, 3'b000, 3'b001, 3'b010);
    vec("b_done",      1, 0, 3'b001, 3'b001, 3'b111, 3'b001, 3'b110, 3'b110, 3'b111, 3'b001, 3'b010);
    vec("b_next",      1, 0, 3'b001, 3'b001, 3'b111, 3'b001, 3'b110, 3'b100, 3'b111, 3'b001, 3'b100);
    vec("b_idle",      1, 0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000);
    // Reset asserted mid-burst in round robin.
    vec("rst_b1",      1, 1, 3'b100, 3'b100, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000);
    vec("rst_b2",      1, 1, 3'b100, 3'b100, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000);
    vec("rst_mid",     0, 1, 3'b100, 3'b100, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    vec("rst_hold",    0, 1, 3'b101, 3'b101, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    vec("rst_rel",     1, 1, 3'b101, 3'b101, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("rst_rel_end", 1, 1, 3'b101, 3'b101, 3'b111, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("rst_s2",      1, 1, 3'b100, 3'b100, 3'b111, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000);
    // Mode change during lock takes effect only at the next arbitration.
    vec("mode_lock",   1, 0, 3'b011, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("mode_flip",   1, 1, 3'b011, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("mode_rel",    1, 1, 3'b011, 3'b011, 3'b111, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("mode_rr0",    1, 1, 3'b011, 3'b011, 3'b111, 3'b011, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    vec("mode_rr1",    1, 1, 3'b011, 3'b011, 3'b111, 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vec("final_idle",  1, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
